// File: rtl/traffic_rr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared types and helpers for the round-robin traffic-light controller.
//   state_t  : controller phase (ALL_RED, GREEN, YELLOW, FLASH)
//   max3     : largest of three phase lengths, used to size the countdown
//   next_rr  : round-robin pick of the next pending direction
// ---------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        FLASH   = 2'd3
    } state_t;

    localparam int unsigned MAX_DIR = 8;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Searches active_dir+1, active_dir+2, ... (mod num_dir) and returns the
    // first direction with a pending request. Returns active_dir when nothing
    // is pending; callers only use the result when pending is non-zero.
    function automatic logic [2:0] next_rr(input logic [MAX_DIR-1:0] pending,
                                           input logic [2:0]         active_dir,
                                           input int unsigned        num_dir);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = active_dir;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_DIR; k++) begin
            if (k <= num_dir) begin
                idx = (32'(active_dir) + k) % num_dir;
                if (!found && pending[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/traffic_rr_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// One-second prescaler: counts 0..DIV-1 and pulses tick for one cycle at
// DIV-1. A synchronous clear restarts the count so every phase begins on a
// fresh second.
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   clear in  synchronous restart of the count
//   tick  out one-cycle pulse every DIV cycles
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int unsigned DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_rr_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_rr_ctrl
// N-direction actuated traffic-light controller. Directions are served
// round-robin on latched car demand; green rests on the served direction
// until another direction asks. Phase lengths are in seconds of an internal
// prescaler.
//   clk        in  system clock
//   reset      in  synchronous active-high reset
//   car        in  per-direction vehicle sensor, sampled every cycle
//   night      in  flash-mode request (only with TRAFFIC_FLASH_EN)
//   red        out red lamp per direction
//   yellow     out yellow lamp per direction
//   green      out green lamp per direction
//   active_dir out direction currently or last served
//   remaining  out seconds left in the current phase
// Build option: define TRAFFIC_FLASH_EN to enable night flashing-yellow mode.
// ---------------------------------------------------------------------------
module traffic_rr_ctrl
    import traffic_pkg::*;
#(
    parameter  int unsigned NUM_DIR   = 4,
    parameter  int unsigned TICK_DIV  = 100_000_000,
    parameter  int unsigned GREEN_S   = 3,
    parameter  int unsigned YELLOW_S  = 1,
    parameter  int unsigned ALL_RED_S = 1,
    localparam int unsigned DW        = $clog2(NUM_DIR),
    localparam int unsigned TW        = $clog2(max3(GREEN_S, YELLOW_S, ALL_RED_S) + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_DIR-1:0] car,
    input  logic               night,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic [DW-1:0]      active_dir,
    output logic [TW-1:0]      remaining
);

    state_t             state, state_d;
    logic [TW-1:0]      rem_d;
    logic [DW-1:0]      dir_d;
    logic [NUM_DIR-1:0] pending, pend_d;
    logic [NUM_DIR-1:0] sel;
    logic [NUM_DIR-1:0] green_mask;
    logic [DW-1:0]      nxt;
    logic               tick;
    logic               clear;
    logic               expire;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    // Prescaler restarts on every phase change so each phase is whole seconds.
    assign clear = (state_d != state);

    assign sel        = NUM_DIR'(1) << active_dir;
    assign green_mask = (state == GREEN) ? sel : '0;
    assign nxt        = DW'(next_rr(8'(pending), 3'(active_dir), NUM_DIR));

    // The phase is treated as over either once the countdown already reads
    // zero, or on the tick that would take it from one to zero; the latter
    // makes a D-second phase last exactly D*TICK_DIV cycles.
    assign expire = (remaining == '0) || (tick && (remaining == TW'(1)));

`ifdef TRAFFIC_FLASH_EN
    logic blink;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink <= 1'b1;
        end else if (state != FLASH) begin
            blink <= 1'b1;
        end else if (tick) begin
            blink <= ~blink;
        end
    end
`endif

    always_comb begin
        state_d = state;
        rem_d   = remaining;
        dir_d   = active_dir;
        pend_d  = pending | (car & ~green_mask);

        case (state)
            ALL_RED: begin
                if (expire && (pending != '0)) begin
                    state_d     = GREEN;
                    dir_d       = nxt;
                    rem_d       = TW'(GREEN_S);
                    pend_d[nxt] = 1'b0;
                end else if (tick && (remaining != '0)) begin
                    rem_d = remaining - TW'(1);
                end
            end
            GREEN: begin
                if (expire && (pending != '0)) begin
                    state_d = YELLOW;
                    rem_d   = TW'(YELLOW_S);
                end else if (tick && (remaining != '0)) begin
                    rem_d = remaining - TW'(1);
                end
            end
            YELLOW: begin
                if (tick && (remaining == TW'(1))) begin
                    state_d = ALL_RED;
                    rem_d   = TW'(ALL_RED_S);
                end else if (tick && (remaining != '0)) begin
                    rem_d = remaining - TW'(1);
                end
            end
            FLASH: begin
`ifdef TRAFFIC_FLASH_EN
                pend_d = '0;
                rem_d  = '0;
                if (!night) begin
                    state_d = ALL_RED;
                    rem_d   = TW'(ALL_RED_S);
                end
`else
                state_d = ALL_RED;
                rem_d   = TW'(ALL_RED_S);
`endif
            end
            default: begin
                state_d = ALL_RED;
                rem_d   = TW'(ALL_RED_S);
            end
        endcase

`ifdef TRAFFIC_FLASH_EN
        if (night) begin
            state_d = FLASH;
            rem_d   = '0;
            pend_d  = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ALL_RED;
            remaining  <= TW'(ALL_RED_S);
            active_dir <= DW'(NUM_DIR - 1);
            pending    <= '0;
        end else begin
            state      <= state_d;
            remaining  <= rem_d;
            active_dir <= dir_d;
            pending    <= pend_d;
        end
    end

    always_comb begin
        red    = '1;
        yellow = '0;
        green  = '0;
        case (state)
            GREEN: begin
                red   = ~sel;
                green = sel;
            end
            YELLOW: begin
                red    = ~sel;
                yellow = sel;
            end
            FLASH: begin
`ifdef TRAFFIC_FLASH_EN
                red    = '0;
                yellow = {NUM_DIR{blink}};
`endif
            end
            default: begin
                red = '1;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_rr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_traffic_rr_ctrl
// Directed bench for traffic_rr_ctrl with TICK_DIV=4, NUM_DIR=4, GREEN_S=3,
// YELLOW_S=1, ALL_RED_S=1. Inputs change and outputs are sampled 1 time unit
// after each rising edge. A green phase with demand elsewhere takes 12
// cycles, yellow 4 and all-red 4, so a full hand-over is 20 cycles.
// ---------------------------------------------------------------------------
module tb_traffic_rr_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] car;
    logic       night;
    logic [3:0] red, yellow, green;
    logic [1:0] active_dir;
    logic [1:0] remaining;

    int n_assert;
    int n_fail;

    traffic_rr_ctrl #(
        .NUM_DIR   (4),
        .TICK_DIV  (4),
        .GREEN_S   (3),
        .YELLOW_S  (1),
        .ALL_RED_S (1)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .car        (car),
        .night      (night),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .active_dir (active_dir),
        .remaining  (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        car      = 4'b0000;
        night    = 1'b0;

        // 1. reset state and idle countdown
        step(2);
        check("rst_red", red, 4'b1111);
        check("rst_yellow", yellow, 4'b0000);
        check("rst_green", green, 4'b0000);
        check("rst_rem", remaining, 2'd1);
        check("rst_dir", active_dir, 2'd3);
        check("rst_pending", u_dut.pending, 4'b0000);
        reset = 1'b0;
        step(3);
        check("idle_rem_1", remaining, 2'd1);
        step(1);
        check("idle_rem_0", remaining, 2'd0);
        step(16);
        check("idle_red", red, 4'b1111);
        check("idle_rem_hold", remaining, 2'd0);
        check("idle_dir", active_dir, 2'd3);

        // 2. single request from idle: green one edge after the latch
        car = 4'b0100;
        step(1);
        car = 4'b0000;
        check("lat_pending", u_dut.pending, 4'b0100);
        check("lat_green_wait", green, 4'b0000);
        step(1);
        check("g2_green", green, 4'b0100);
        check("g2_red", red, 4'b1011);
        check("g2_dir", active_dir, 2'd2);
        check("g2_rem3", remaining, 2'd3);
        check("g2_pending_clr", u_dut.pending, 4'b0000);
        step(3);
        check("g2_rem3_end", remaining, 2'd3);
        step(1);
        check("g2_rem2", remaining, 2'd2);
        step(4);
        check("g2_rem1", remaining, 2'd1);
        step(4);
        check("g2_rem0", remaining, 2'd0);
        step(8);
        check("g2_rest_green", green, 4'b0100);
        check("g2_rest_rem", remaining, 2'd0);

        // 3. request on dir0 while dir2 rests on green
        car = 4'b0001;
        step(1);
        car = 4'b0000;
        check("h3_still_green", green, 4'b0100);
        step(1);
        check("h3_yellow", yellow, 4'b0100);
        check("h3_yel_green", green, 4'b0000);
        check("h3_yel_red", red, 4'b1011);
        check("h3_yel_rem", remaining, 2'd1);
        step(3);
        check("h3_yellow_end", yellow, 4'b0100);
        step(1);
        check("h3_allred", red, 4'b1111);
        check("h3_allred_yel", yellow, 4'b0000);
        check("h3_allred_rem", remaining, 2'd1);
        step(3);
        check("h3_allred_end", red, 4'b1111);
        step(1);
        check("h3_green0", green, 4'b0001);
        check("h3_dir0", active_dir, 2'd0);
        check("h3_rem", remaining, 2'd3);
        check("h3_pending", u_dut.pending, 4'b0000);

        // 4. get dir1 green, then latch dir3 and dir0; dir1 pulses are ignored
        car = 4'b0010;
        step(1);
        car = 4'b0000;
        step(10);
        check("h4_g0_hold", green, 4'b0001);
        step(1);
        check("h4_g0_yellow", yellow, 4'b0001);
        step(8);
        check("h4_green1", green, 4'b0010);
        check("h4_dir1", active_dir, 2'd1);
        car = 4'b1001;
        step(1);
        car = 4'b0010;
        step(1);
        car = 4'b0000;
        check("h4_latched", u_dut.pending, 4'b1001);
        step(18);
        check("h4_green3", green, 4'b1000);
        check("h4_dir3", active_dir, 2'd3);
        check("h4_pend_after3", u_dut.pending, 4'b0001);
        step(20);
        check("h4_green0", green, 4'b0001);
        check("h4_dir0", active_dir, 2'd0);
        check("h4_pend_empty", u_dut.pending, 4'b0000);
        step(24);
        check("h4_rest0", green, 4'b0001);

        // 5. reset during yellow with dir3 pending
        car = 4'b1000;
        step(1);
        car = 4'b0000;
        step(1);
        check("r5_yellow", yellow, 4'b0001);
        check("r5_pending", u_dut.pending, 4'b1000);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("r5_red", red, 4'b1111);
        check("r5_yellow_off", yellow, 4'b0000);
        check("r5_pending_clr", u_dut.pending, 4'b0000);
        check("r5_dir", active_dir, 2'd3);
        check("r5_rem", remaining, 2'd1);
        step(3);
        check("r5_rem_hold", remaining, 2'd1);
        step(1);
        check("r5_rem0", remaining, 2'd0);
        step(4);
        check("r5_no_green", green, 4'b0000);

        // 6. night request while dir1 is green
        car = 4'b0010;
        step(1);
        car = 4'b0000;
        step(1);
        check("n6_green1", green, 4'b0010);
        night = 1'b1;
        step(1);
`ifdef TRAFFIC_FLASH_EN
        check("n6_flash_yel", yellow, 4'b1111);
        check("n6_flash_red", red, 4'b0000);
        check("n6_flash_green", green, 4'b0000);
        check("n6_flash_rem", remaining, 2'd0);
        step(3);
        check("n6_blink_on", yellow, 4'b1111);
        step(1);
        check("n6_blink_off", yellow, 4'b0000);
        step(4);
        check("n6_blink_on2", yellow, 4'b1111);
        night = 1'b0;
        step(1);
        check("n6_exit_red", red, 4'b1111);
        check("n6_exit_yel", yellow, 4'b0000);
        check("n6_exit_rem", remaining, 2'd1);
        check("n6_exit_pend", u_dut.pending, 4'b0000);
`else
        check("n6_ignored_green", green, 4'b0010);
        step(8);
        check("n6_ignored_hold", green, 4'b0010);
        check("n6_ignored_yel", yellow, 4'b0000);
        night = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_rr_ctrl.md
Name: traffic_rr_ctrl

Overview:
- Parametrised N-direction actuated traffic-light controller; successor to the fixed two-road highway/farm controller.
- Serves directions round-robin on latched car demand, with parameter-set green, yellow and all-red phase lengths in seconds.
- Exposes the active direction and the seconds remaining in the current phase for the seven-segment display path.
- Sits beside the clock/counter logic at top level and owns its own one-second prescaler.

Parameters:
NUM_DIR, 4, number of directions (2..8)
TICK_DIV, 100_000_000, clk cycles per one-second tick
GREEN_S, 3, minimum green time in seconds (>=1)
YELLOW_S, 1, yellow time in seconds (>=1)
ALL_RED_S, 1, all-red clearance time in seconds (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
car  in  NUM_DIR  per-direction vehicle sensor; sampled every cycle
night  in  1  flash-mode request; used only with TRAFFIC_FLASH_EN, otherwise ignored
red  out  NUM_DIR  red lamp per direction
yellow  out  NUM_DIR  yellow lamp per direction
green  out  NUM_DIR  green lamp per direction
active_dir  out  $clog2(NUM_DIR)  direction currently or last served
remaining  out  TW  seconds left in the current phase; TW = $clog2(max(GREEN_S,YELLOW_S,ALL_RED_S)+1)

Behaviour:
- Reset values (held while reset=1, applied on the clk edge):
  - state ALL_RED, remaining=ALL_RED_S, active_dir=NUM_DIR-1.
  - pending=0, prescaler=0.
  - Outputs: red all 1, yellow 0, green 0.
- Reset mid-operation: same result regardless of state.
- Prescaler: counts 0..TICK_DIV-1; tick is a 1-cycle pulse at count TICK_DIV-1. The prescaler clears on every state change, so a phase of D seconds lasts exactly D*TICK_DIV cycles.
- Demand latch:
  - pending[i] is set at the edge where car[i]=1, unless i is currently green.
  - pending[i] is cleared when i enters GREEN.
- States and transitions:
  - ALL_RED:
    - On a tick, remaining decrements.
    - When remaining==0 and pending!=0: go to GREEN of the next pending direction at the next edge.
    - Next pending direction = round-robin search from active_dir+1 (mod NUM_DIR).
    - Set active_dir to that direction; load remaining=GREEN_S.
    - When remaining==0 and pending==0: idle in ALL_RED.
  - GREEN:
    - On a tick, remaining decrements (saturates at 0).
    - When remaining==0 and any pending bit is set: go to YELLOW at the next edge, remaining=YELLOW_S. (The active bit is never set in GREEN.)
    - Otherwise hold green (rest-on-green).
  - YELLOW:
    - On a tick with remaining==1: go to ALL_RED, remaining=ALL_RED_S.
    - Otherwise decrement on a tick.
  - ALL_RED (after YELLOW) then follows the rules above.
- Latency: a car pulse sampled at edge t sets pending at t. An idle ALL_RED controller shows green from edge t+1.
- Lamps are combinational from state and active_dir.
  - Served direction: green or yellow per state.
  - Every other direction: red only.
  - In ALL_RED every direction is red.
  - Exactly one lamp per direction is lit, except in flash mode.

Optional Feature:
- Macro TRAFFIC_FLASH_EN.
- Defined: night=1 forces state FLASH at the next edge from any state.
  - In FLASH: red=0, green=0, all yellow bits equal blink.
  - blink starts at 1 and toggles on every tick.
  - pending is cleared and held at 0; remaining=0.
  - night=0 leaves FLASH for ALL_RED with remaining=ALL_RED_S.
- Undefined: night is ignored, the FLASH state is unreachable, and no blink register exists.

Decomposition:
- Package traffic_pkg:
  - state_t enum {ALL_RED, GREEN, YELLOW, FLASH}.
  - Function next_rr(pending, active_dir) returning the next pending direction.
- Sub-module tick_gen (prescaler with synchronous clear input and tick output), parameter DIV.

Test Plan:
All scenarios use TICK_DIV=4, NUM_DIR=4, GREEN_S=3, YELLOW_S=1, ALL_RED_S=1.
1. Reset, then car=0 for 20 cycles -> red=4'b1111, remaining=1 for 4 cycles then 0, active_dir=3.
2. Idle, then car=4'b0100 for one cycle -> green=4'b0100 one edge later, active_dir=2, remaining 3→2→1→0 every 4 cycles, then held green.
3. Dir2 resting green, car[0] pulse -> next edge yellow=4'b0100 for 4 cycles, then red=4'b1111 for 4 cycles, then green=4'b0001, pending[0]=0.
4. Dir1 green with car[3] and car[0] latched -> served in order 3 then 0; a car[1] pulse during dir1 green is not latched.
5. Assert reset for 1 cycle mid-YELLOW with pending=4'b1000 -> red=4'b1111, pending=0, active_dir=3, remaining=1.
6. TRAFFIC_FLASH_EN defined, night=1 during GREEN -> next edge yellow=4'b1111, toggling every 4 cycles; night=0 -> ALL_RED with remaining=1.
